// File: rtl/iob_cache_write_channel_axi_burst.sv
`default_nettype none
// ============================================================================
//  Module   : iob_cache_write_channel_axi_burst
//  Purpose  : AXI4 write-back channel for the cache back-end. Accepts one
//             full cache-line write request and buffers it. It then sends the
//             line as one INCR burst of LINE_W/BE_DATA_W beats. The AW and W
//             channels run concurrently and handshake independently. If the
//             B response is SLVERR/DECERR, the same buffered line is sent
//             again, up to MAX_RETRY times. After that the line is dropped
//             and a one-cycle error pulse is raised.
//
//  Ports    : clk, reset_n            clock, asynchronous active-low reset
//             valid, ready            front-end request handshake
//             addr                    line address (byte address >> LOFF_W)
//             wdata                   line data, beat 0 in the LSBs
//             wstrb                   line byte enables (optional feature)
//             error                   retries exhausted, line dropped
//             axi_aw*, axi_w*, axi_b* AXI4 write address/data/response
//
//  Option   : IOB_CACHE_WCH_WSTRB_EN
//             When defined, the wstrb port exists and is buffered with the
//             line. When undefined, the port is absent and axi_wstrb is all
//             ones.
//
//  Revision : 1.0  initial release
// ============================================================================
module iob_cache_write_channel_axi_burst #(
    parameter int ADDR_W    = 32,
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 32,
    parameter int LINE_W    = 128,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_ID    = 0,
    parameter int MAX_RETRY = 3
) (
    input  logic                                 clk,
    input  logic                                 reset_n,

    // front-end line write request
    input  logic                                 valid,
    input  logic [ADDR_W-$clog2(LINE_W/8)-1:0]   addr,
    input  logic [LINE_W-1:0]                    wdata,
`ifdef IOB_CACHE_WCH_WSTRB_EN
    input  logic [LINE_W/8-1:0]                  wstrb,
`endif
    output logic                                 ready,
    output logic                                 error,

    // AXI write address channel
    output logic                                 axi_awvalid,
    input  logic                                 axi_awready,
    output logic [BE_ADDR_W-1:0]                 axi_awaddr,
    output logic [7:0]                           axi_awlen,
    output logic [2:0]                           axi_awsize,
    output logic [1:0]                           axi_awburst,
    output logic [0:0]                           axi_awlock,
    output logic [3:0]                           axi_awcache,
    output logic [2:0]                           axi_awprot,
    output logic [3:0]                           axi_awqos,
    output logic [AXI_ID_W-1:0]                  axi_awid,

    // AXI write data channel
    output logic                                 axi_wvalid,
    input  logic                                 axi_wready,
    output logic [BE_DATA_W-1:0]                 axi_wdata,
    output logic [BE_DATA_W/8-1:0]               axi_wstrb,
    output logic                                 axi_wlast,

    // AXI write response channel
    input  logic                                 axi_bvalid,
    input  logic [1:0]                           axi_bresp,
    output logic                                 axi_bready
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int N       = LINE_W / BE_DATA_W;
    localparam int LOFF_W  = $clog2(LINE_W / 8);
    localparam int LADDR_W = ADDR_W - LOFF_W;
    localparam int STRB_W  = BE_DATA_W / 8;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(N - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                          state_q;
    logic [LADDR_W-1:0]              addr_q;
    logic [N-1:0][BE_DATA_W-1:0]     data_q;
    logic [CNT_W-1:0]                beat_q;
    logic [RETRY_W-1:0]              retry_q;
    logic                            aw_done_q;
    logic                            ready_q;
    logic                            awvalid_q;
    logic                            wvalid_q;
    logic                            bready_q;
    logic                            error_q;
`ifdef IOB_CACHE_WCH_WSTRB_EN
    logic [N-1:0][STRB_W-1:0]        strb_q;
`endif

    // ------------------------------------------------------------------------
    // Handshake decode for the current cycle
    // ------------------------------------------------------------------------
    logic is_last_beat;
    logic aw_hs;
    logic w_hs;
    logic w_last_hs;
    logic aw_finished;
    logic w_finished;
    logic b_hs;
    logic b_is_error;
    logic retry_left;

    assign is_last_beat = (beat_q == LAST_BEAT);
    assign aw_hs        = awvalid_q & axi_awready;
    assign w_hs         = wvalid_q & axi_wready;
    assign w_last_hs    = w_hs & is_last_beat;

    // Both channels count as finished if they finished earlier or if their
    // final handshake happens in this cycle. So AW and the last W beat may
    // complete in either order, or together.
    assign aw_finished  = aw_done_q | aw_hs;
    // Inside XFER, a low wvalid can only mean that the last beat already went out.
    assign w_finished   = ~wvalid_q | w_last_hs;

    assign b_hs         = bready_q & axi_bvalid;
    assign b_is_error   = axi_bresp[1];
    assign retry_left   = (retry_q < RETRY_MAX);

    // bresp[0] only separates OKAY from EXOKAY (and SLVERR from DECERR).
    // Both sides of each pair are handled the same way.
    logic bresp_lsb_unused;
    assign bresp_lsb_unused = axi_bresp[0];

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            beat_q    <= '0;
            retry_q   <= '0;
            aw_done_q <= 1'b0;
            ready_q   <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            error_q   <= 1'b0;
`ifdef IOB_CACHE_WCH_WSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            error_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (valid && ready_q) begin
                        addr_q    <= addr;
                        data_q    <= wdata;
`ifdef IOB_CACHE_WCH_WSTRB_EN
                        strb_q    <= wstrb;
`endif
                        retry_q   <= '0;
                        beat_q    <= '0;
                        aw_done_q <= 1'b0;
                        ready_q   <= 1'b0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                        awvalid_q <= 1'b0;
                    end

                    // The beat counter stops on the last beat. It is cleared
                    // again when the burst starts or is retried.
                    if (w_hs) begin
                        if (is_last_beat) begin
                            wvalid_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + CNT_W'(1);
                        end
                    end

                    if (aw_finished && w_finished) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (!b_is_error) begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (retry_left) begin
                            // Send the same buffered line again from beat 0.
                            retry_q   <= retry_q + RETRY_W'(1);
                            beat_q    <= '0;
                            aw_done_q <= 1'b0;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_XFER;
                        end else begin
                            // Retries are used up: drop the line and report it.
                            error_q <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] line_byte_addr;
    assign line_byte_addr = ADDR_W'(addr_q) << LOFF_W;

    assign ready       = ready_q;
    assign error       = error_q;

    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = BE_ADDR_W'(line_byte_addr);
    assign axi_awlen   = 8'(N - 1);
    assign axi_awsize  = 3'($clog2(STRB_W));
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = 4'b0011;
    assign axi_awprot  = 3'b000;
    assign axi_awqos   = 4'b0000;
    assign axi_awid    = AXI_ID_W'(AXI_ID);

    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = data_q[beat_q];
    // For N == 1 the counter is always at its last value, so wlast follows wvalid.
    assign axi_wlast   = wvalid_q & is_last_beat;

`ifdef IOB_CACHE_WCH_WSTRB_EN
    assign axi_wstrb   = strb_q[beat_q];
`else
    assign axi_wstrb   = '1;
`endif

    assign axi_bready  = bready_q;

endmodule
`default_nettype wire
